// File: rtl/digi_readout.sv
// digi_readout: drains 12-bit words from the digitizer global FIFO, parses them
// into frames (one bunch-crossing header followed by `howmany` samples) and
// presents 32-bit words, two samples per word, over a valid/ready handshake.
module digi_readout #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned SIZE  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] FIFO_DOUT,
  input  logic             FIFO_EMPTY,
  output logic             FIFO_RD_REQUEST,
  input  logic [SIZE-1:0]  howmany,
  output logic [31:0]      M_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic             M_LAST,
  output logic [15:0]      FRAME_CNT
);

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned COUNT_W  = 8;
  localparam logic [7:0]  HDR_TAG  = 8'hA5;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, OUT} state_t;
  typedef enum logic [1:0] {HDR, LO, HI} phase_t;

  state_t            state;
  phase_t            phase;
  logic [SIZE-1:0]   remaining;
  logic [SIZE-1:0]   rem_dec;
  logic [SAMPLE_W-1:0] sample;

  // Samples left after consuming the word currently on FIFO_DOUT.
  assign rem_dec = remaining - SIZE'(1);
  assign sample  = SAMPLE_W'(FIFO_DOUT);

  // Read only from FETCH and only when data exists, so the FIFO is never over-read.
  assign FIFO_RD_REQUEST = (state == FETCH) && !FIFO_EMPTY;

  // Frame parser: fetch one word, capture it into the slot selected by phase, emit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      phase     <= HDR;
      remaining <= '0;
      M_DATA    <= '0;
      M_VALID   <= 1'b0;
      M_LAST    <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;

        FETCH: begin
          if (!FIFO_EMPTY) state <= WAIT;
        end

        WAIT: begin
          case (phase)
            HDR: begin
              remaining <= howmany;
              M_DATA    <= {HDR_TAG, 4'h0, COUNT_W'(howmany), sample};
              M_LAST    <= (howmany == '0);
              M_VALID   <= 1'b1;
              state     <= OUT;
            end
            LO: begin
              remaining <= rem_dec;
              M_DATA    <= {20'h0, sample};
              if (rem_dec == '0) begin
                M_LAST  <= 1'b1;
                M_VALID <= 1'b1;
                state   <= OUT;
              end else begin
                phase   <= HI;
                state   <= FETCH;
              end
            end
            HI: begin
              remaining     <= rem_dec;
              M_DATA[31:12] <= {4'h0, sample, 4'h0};
              M_LAST        <= (rem_dec == '0);
              M_VALID       <= 1'b1;
              state         <= OUT;
            end
            default: begin
              phase <= HDR;
              state <= FETCH;
            end
          endcase
        end

        OUT: begin
          if (M_READY) begin
            M_VALID <= 1'b0;
            M_LAST  <= 1'b0;
            state   <= FETCH;
            if (M_LAST) begin
              phase     <= HDR;
              FRAME_CNT <= FRAME_CNT + 16'd1;
            end else begin
              phase     <= LO;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digi_readout.sv
// Directed bench for digi_readout with a behavioural non-show-ahead FIFO.
module tb_digi_readout;

  localparam int unsigned WIDTH = 12;
  localparam int unsigned SIZE  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_empty;
  logic             fifo_rd_request;
  logic [SIZE-1:0]  howmany = '0;
  logic [31:0]      m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             m_last;
  logic [15:0]      frame_cnt;

  logic [WIDTH-1:0] mem [0:255];
  int wr_ptr     = 0;
  int rd_ptr     = 0;
  int rd_count   = 0;
  int violations = 0;
  int tests      = 0;
  int fails      = 0;

  digi_readout #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .CLK             (clk),
    .RST             (rst),
    .FIFO_DOUT       (fifo_dout),
    .FIFO_EMPTY      (fifo_empty),
    .FIFO_RD_REQUEST (fifo_rd_request),
    .howmany         (howmany),
    .M_DATA          (m_data),
    .M_VALID         (m_valid),
    .M_READY         (m_ready),
    .M_LAST          (m_last),
    .FRAME_CNT       (frame_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO model: q valid the cycle after rdreq; cleared by the shared reset.
  always @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= wr_ptr;
      rd_count <= 0;
    end else if (fifo_rd_request) begin
      rd_count <= rd_count + 1;
      if (fifo_empty || m_valid) begin
        violations <= violations + 1;
      end else begin
        fifo_dout <= mem[8'(rd_ptr)];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    mem[8'(wr_ptr)] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!m_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(m_valid), 32'd1);
  endtask

  task automatic get_word(input string tag, input logic [31:0] exp_data, input logic exp_last);
    wait_valid(tag);
    check({tag, "_data"}, m_data, exp_data);
    check({tag, "_last"}, 32'(m_last), 32'(exp_last));
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_drop"}, 32'(m_valid), 32'd0);
  endtask

  initial begin
    int rd0;
    int bad;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", m_data, 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    check("rst_req", 32'(fifo_rd_request), 32'd0);
    rst = 1'b0;

    // 1: odd sample count
    howmany = 8'd3;
    m_ready = 1'b1;
    rd0 = rd_count;
    push(12'h123); push(12'h001); push(12'h002); push(12'h003);
    get_word("t1_hdr", 32'hA500_3123, 1'b0);
    get_word("t1_w1", 32'h0002_0001, 1'b0);
    get_word("t1_w2", 32'h0000_0003, 1'b1);
    check("t1_cnt", 32'(frame_cnt), 32'd1);
    check("t1_reads", 32'(rd_count - rd0), 32'd4);

    // 2: zero-sample frame
    howmany = 8'd0;
    push(12'h7FF);
    get_word("t2_hdr", 32'hA500_07FF, 1'b1);
    check("t2_cnt", 32'(frame_cnt), 32'd2);
    rd0 = rd_count;
    repeat (5) @(negedge clk);
    check("t2_noread", 32'(rd_count - rd0), 32'd0);
    check("t2_req", 32'(fifo_rd_request), 32'd0);

    // 3: backpressure on the header word
    howmany = 8'd2;
    m_ready = 1'b0;
    push(12'h055); push(12'hAAA); push(12'hBBB);
    wait_valid("t3_hdr");
    check("t3_hdr_data", m_data, 32'hA500_2055);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_data !== 32'hA500_2055 || m_valid !== 1'b1 || fifo_rd_request !== 1'b0 ||
          (wr_ptr - rd_ptr) != 2)
        bad++;
    end
    check("t3_hold", 32'(bad), 32'd0);
    check("t3_level", 32'(wr_ptr - rd_ptr), 32'd2);
    m_ready = 1'b1;
    get_word("t3_w1", 32'h0BBB_0AAA, 1'b1);
    check("t3_cnt", 32'(frame_cnt), 32'd3);

    // 4: FIFO runs empty mid-frame
    howmany = 8'd4;
    push(12'h0C4); push(12'h011); push(12'h022);
    get_word("t4_hdr", 32'hA500_40C4, 1'b0);
    get_word("t4_w1", 32'h0022_0011, 1'b0);
    rd0 = rd_count;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || fifo_rd_request !== 1'b0) bad++;
    end
    check("t4_stall", 32'(bad), 32'd0);
    check("t4_noread", 32'(rd_count - rd0), 32'd0);
    push(12'h033); push(12'h044);
    get_word("t4_w2", 32'h0044_0033, 1'b1);
    check("t4_cnt", 32'(frame_cnt), 32'd4);

    // 5: reset during the first sample pair
    howmany = 8'd4;
    push(12'h200); push(12'h101); push(12'h102); push(12'h103); push(12'h104);
    get_word("t5_hdr", 32'hA500_4200, 1'b0);
    m_ready = 1'b0;
    wait_valid("t5_w1");
    check("t5_w1_data", m_data, 32'h0102_0101);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(m_valid), 32'd0);
    check("t5_rst_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t5_fifo_clr", 32'(wr_ptr - rd_ptr), 32'd0);
    howmany = 8'd1;
    m_ready = 1'b1;
    push(12'h3AB); push(12'h05A);
    get_word("t5_hdr2", 32'hA500_13AB, 1'b0);
    get_word("t5_w2", 32'h0000_005A, 1'b1);
    check("t5_cnt", 32'(frame_cnt), 32'd1);

    // 6: counter wrap and howmany change mid-frame
    force dut.FRAME_CNT = 16'hFFFF;
    #1;
    release dut.FRAME_CNT;
    check("t6_preset", 32'(frame_cnt), 32'h0000_FFFF);
    howmany = 8'd3;
    push(12'h0E1); push(12'h0D1); push(12'h0D2); push(12'h0D3);
    get_word("t6_hdr", 32'hA500_30E1, 1'b0);
    howmany = 8'd1;
    get_word("t6_w1", 32'h00D2_00D1, 1'b0);
    get_word("t6_w2", 32'h0000_00D3, 1'b1);
    check("t6_wrap", 32'(frame_cnt), 32'd0);
    push(12'h0E2); push(12'h0F1);
    get_word("t6_hdr2", 32'hA500_10E2, 1'b0);
    get_word("t6_w3", 32'h0000_00F1, 1'b1);
    check("t6_cnt", 32'(frame_cnt), 32'd1);

    check("overread", 32'(violations), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
